// File: rtl/booth_mac_ctrl.sv
// booth_mac_ctrl: sequences operand pairs into the 6x6 Booth multiplier
// and accumulates the products into a saturating signed dot product.
module booth_mac_ctrl #(
  parameter int ACC_W   = 16,
  parameter int MUL_LAT = 26
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_m,
  input  logic [5:0]       in_q,
  input  logic             in_last,
  output logic             mul_start,
  output logic [5:0]       mul_m,
  output logic [5:0]       mul_q,
  input  logic [11:0]      mul_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_sat
);

  localparam int WCW = $clog2(MUL_LAT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_CAPT   = 3'd3;
  localparam logic [2:0] S_OUT    = 3'd4;

  localparam logic [ACC_W-1:0] ACC_MAX =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN =
    {1'b1, {(ACC_W-1){1'b0}}};

  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [WCW-1:0]   wcnt;
  logic             last_r;
  logic [ACC_W-1:0] acc;
  logic             sat;

  logic st_idle;
  logic st_launch;
  logic st_wait;
  logic st_capt;
  logic st_out;

  logic [ACC_W:0]   sum_c;
  logic             pos_ovf;
  logic             neg_ovf;
  logic [ACC_W-1:0] acc_nx;

  assign st_idle   = (state_q == S_IDLE);
  assign st_launch = (state_q == S_LAUNCH);
  assign st_wait   = (state_q == S_WAIT);
  assign st_capt   = (state_q == S_CAPT);
  assign st_out    = (state_q == S_OUT);

  assign in_ready  = st_idle & n_rst;
  assign mul_start = st_launch;
  assign out_valid = st_out;
  assign out_data  = acc;
  assign out_sat   = sat;

  // Widened add and clamp of the captured product into the accumulator
  always_comb begin
    sum_c = {acc[ACC_W-1], acc}
          + {{(ACC_W-11){mul_result[11]}}, mul_result};
    pos_ovf = ~sum_c[ACC_W] & sum_c[ACC_W-1];
    neg_ovf = sum_c[ACC_W] & ~sum_c[ACC_W-1];
    acc_nx = sum_c[ACC_W-1:0];
    if (pos_ovf) acc_nx = ACC_MAX;
    if (neg_ovf) acc_nx = ACC_MIN;
  end

  // Next-state decode of the sequencing FSM
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      st_idle:   if (in_valid) state_d = S_LAUNCH;
      st_launch: state_d = S_WAIT;
      st_wait:   if (wcnt == '0) state_d = S_CAPT;
      st_capt:   state_d = last_r ? S_OUT : S_IDLE;
      st_out:    if (out_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // State, operand hold, latency count and accumulator registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      wcnt    <= '0;
      last_r  <= 1'b0;
      mul_m   <= '0;
      mul_q   <= '0;
      acc     <= '0;
      sat     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (st_idle && in_valid) begin
        mul_m  <= in_m;
        mul_q  <= in_q;
        last_r <= in_last;
      end
      if (st_launch) begin
        wcnt <= WCW'(MUL_LAT - 2);
      end else if (st_wait) begin
        wcnt <= wcnt - 1'b1;
      end
      if (st_capt) begin
        acc <= acc_nx;
        if (pos_ovf || neg_ovf) sat <= 1'b1;
      end
      if (st_out && out_ready) begin
        acc <= '0;
        sat <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_booth_mac_ctrl.sv
// tb_booth_mac_ctrl: directed bench for booth_mac_ctrl with a
// behavioural multiplier and a queue of expected dot products.
module tb_booth_mac_ctrl;

  localparam int ACC_W   = 16;
  localparam int MUL_LAT = 26;
  localparam int AMAX    = 32767;
  localparam int AMIN    = -32768;

  logic             clk;
  logic             n_rst;
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       in_m;
  logic [5:0]       in_q;
  logic             in_last;
  logic             mul_start;
  logic [5:0]       mul_m;
  logic [5:0]       mul_q;
  logic [11:0]      mul_result;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_sat;

  int checks;
  int failures;

  int  macc;
  bit  msat;
  logic [16:0] q_exp[$];

  int          k;
  logic [5:0]  pm;
  logic [5:0]  pq;
  logic [11:0] pp;

  booth_mac_ctrl #(.ACC_W(ACC_W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk),
    .n_rst(n_rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_m(in_m),
    .in_q(in_q),
    .in_last(in_last),
    .mul_start(mul_start),
    .mul_m(mul_m),
    .mul_q(mul_q),
    .mul_result(mul_result),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_sat(out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Multiplier stand-in: product valid only in the sampling cycle
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      k <= 0;
    end else if (mul_start) begin
      k  <= 1;
      pm <= mul_m;
      pq <= mul_q;
      pp <= 12'(int'($signed(mul_m)) * int'($signed(mul_q)));
    end else if (k != 0 && k < MUL_LAT) begin
      k <= k + 1;
    end else begin
      k <= 0;
    end
  end

  assign mul_result = (k == MUL_LAT) ? pp : 12'h5a5;

  // Operands must hold from launch through capture
  always @(negedge clk) begin
    if (n_rst && k != 0) begin
      chk("hold_m", 32'(mul_m), 32'(pm));
      chk("hold_q", 32'(mul_q), 32'(pq));
    end
  end

  task automatic send(input int m, input int q,
                      input bit last, output int n);
    int s;
    in_m = 6'(m);
    in_q = 6'(q);
    in_last = last;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 32'(n < 200), 32'd1);
    @(posedge clk);
    for (int i = 1; i <= 28; i++) begin
      @(negedge clk);
      if (i < 28) begin
        chk("start", 32'(mul_start), 32'(i == 1));
        chk("busy_ready", 32'(in_ready), 32'd0);
        chk("busy_ovalid", 32'(out_valid), 32'd0);
        in_m = 6'($urandom);
        in_q = 6'($urandom);
        if (i == 27) in_valid = 1'b0;
      end else begin
        chk("end_ready", 32'(in_ready), 32'(!last));
        chk("end_ovalid", 32'(out_valid), 32'(last));
      end
    end
    s = macc + m * q;
    if (s > AMAX) begin
      s = AMAX;
      msat = 1'b1;
    end
    if (s < AMIN) begin
      s = AMIN;
      msat = 1'b1;
    end
    macc = s;
    if (last) begin
      q_exp.push_back({msat, 16'(macc)});
      macc = 0;
      msat = 1'b0;
    end
  endtask

  task automatic recv();
    logic [16:0] e;
    chk("q_nonempty", 32'(q_exp.size() != 0), 32'd1);
    e = (q_exp.size() != 0) ? q_exp.pop_front() : '0;
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("out_data", 32'(out_data), 32'(e[15:0]));
    chk("out_sat", 32'(out_sat), 32'(e[16]));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_ready", 32'(in_ready), 32'd1);
    chk("post_ovalid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int n;
    logic [16:0] e;
    checks = 0;
    failures = 0;
    macc = 0;
    msat = 1'b0;
    n_rst = 1'b0;
    in_valid = 1'b0;
    in_m = '0;
    in_q = '0;
    in_last = 1'b0;
    out_ready = 1'b0;

    #1;
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_start", 32'(mul_start), 32'd0);
    chk("rst_ovalid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_sat", 32'(out_sat), 32'd0);
    chk("rst_m", 32'(mul_m), 32'd0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    send(3, -2, 1'b1, n);
    chk("single_const", 32'(out_data), 32'hfffa);
    recv();

    send(5, 7, 1'b0, n);
    send(-4, 6, 1'b0, n);
    send(-32, -32, 1'b0, n);
    send(31, -1, 1'b1, n);
    chk("dot_const", 32'(out_data), 32'd1004);
    recv();

    for (int i = 0; i < 32; i++) send(-32, -32, i == 31, n);
    chk("psat_const", 32'(out_data), 32'h7fff);
    recv();
    send(1, 1, 1'b1, n);
    recv();

    for (int i = 0; i < 34; i++) send(-32, 31, i == 33, n);
    chk("nsat_const", 32'(out_data), 32'h8000);
    recv();

    send(-7, 9, 1'b1, n);
    e = q_exp[0];
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_m = 6'($urandom);
      in_q = 6'($urandom);
      chk("bp_ovalid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'(e[15:0]));
      chk("bp_sat", 32'(out_sat), 32'(e[16]));
      chk("bp_ready", 32'(in_ready), 32'd0);
      chk("bp_start", 32'(mul_start), 32'd0);
      @(negedge clk);
    end
    recv();
    send(11, -5, 1'b1, n);
    chk("bp_next_wait", 32'(n), 32'd0);
    recv();

    send(4, 4, 1'b0, n);
    in_m = 6'd7;
    in_q = 6'd7;
    in_last = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    chk("mid_ready", 32'(in_ready), 32'd0);
    chk("mid_start", 32'(mul_start), 32'd0);
    chk("mid_ovalid", 32'(out_valid), 32'd0);
    chk("mid_data", 32'(out_data), 32'd0);
    chk("mid_sat", 32'(out_sat), 32'd0);
    chk("mid_m", 32'(mul_m), 32'd0);
    chk("mid_q", 32'(mul_q), 32'd0);
    macc = 0;
    msat = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    send(2, -3, 1'b1, n);
    chk("rst_after_const", 32'(out_data), 32'hfffa);
    recv();

    chk("q_drained", 32'(q_exp.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
